queue_calc_sequencer: RTL and testbench

Command-level controller for the 5-entry 8-bit operand queue of the calculator datapath. It accepts operand/operation commands over a valid/ready handshake and drives the queue opcode/back bus. It computes the ALU result from the queue's front pair and writes it back, and returns results to the requester. It mirrors queue occupancy, rejects illegal commands before they reach the queue, and latches the queue's error flag.

---
 rtl/queue_calc_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_queue_calc_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_calc_sequencer.sv
// Command sequencer for the calculator operand queue: it accepts PUSH/REDUCE/RESULT/CLEAR
// commands, drives the queue opcode bus, runs the ALU on the front pair and latches errors.
module queue_calc_sequencer #(
    parameter int W     = 8,
    parameter int DEPTH = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_type,
    input  logic [W-1:0]   cmd_data,
    input  logic [1:0]     cmd_aluop,
    output logic [1:0]     q_opcode,
    output logic [W-1:0]   q_back,
    input  logic [2*W-1:0] q_top_conc,
    input  logic           q_is_err,
    output logic           res_valid,
    output logic [W-1:0]   res_data,
    output logic [2:0]     count,
    output logic           busy,
    output logic           err,
    output logic [1:0]     err_code,
    input  logic           err_clr
);

    localparam logic [1:0] CMD_PUSH   = 2'b00;
    localparam logic [1:0] CMD_REDUCE = 2'b01;
    localparam logic [1:0] CMD_RESULT = 2'b10;

    localparam logic [1:0] OP_PUSH    = 2'b00;
    localparam logic [1:0] OP_NOP     = 2'b01;
    localparam logic [1:0] OP_REPLACE = 2'b10;
    localparam logic [1:0] OP_POP     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OVF   = 2'b01;
    localparam logic [1:0] ERR_UNF   = 2'b10;
    localparam logic [1:0] ERR_QUEUE = 2'b11;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_CALC,
        S_WRITE,
        S_POP,
        S_CLEAR,
        S_ERR
    } state_t;

    state_t         state_reg;
    logic [1:0]     q_opcode_reg;
    logic [W-1:0]   data_reg;
    logic [1:0]     aluop_reg;
    logic [W-1:0]   alu_reg;
    logic           res_valid_reg;
    logic [W-1:0]   res_data_reg;
    logic [2:0]     count_reg;
    logic [1:0]     err_code_reg;

    logic           handshake;
    logic [W-1:0]   opnd_a;
    logic [W-1:0]   opnd_b;
    logic [W-1:0]   alu_next;

    assign handshake = cmd_valid && (state_reg == S_IDLE);

    // front entry is operand a, the one behind it is operand b
    always_comb begin
        opnd_a = q_top_conc[W-1:0];
        opnd_b = q_top_conc[2*W-1:W];
        case (aluop_reg)
            ALU_ADD: alu_next = opnd_a + opnd_b;
            ALU_SUB: alu_next = opnd_a - opnd_b;
            ALU_AND: alu_next = opnd_a & opnd_b;
            default: alu_next = opnd_a ^ opnd_b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            q_opcode_reg  <= OP_NOP;
            data_reg      <= '0;
            aluop_reg     <= 2'b00;
            alu_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            count_reg     <= 3'd0;
            err_code_reg  <= ERR_NONE;
        end else begin
            res_valid_reg <= 1'b0;
            if ((state_reg != S_ERR) && q_is_err) begin
                // a queue fault aborts whatever is in flight, including a same-cycle illegal command
                state_reg    <= S_ERR;
                q_opcode_reg <= OP_NOP;
                err_code_reg <= ERR_QUEUE;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (handshake) begin
                            data_reg  <= cmd_data;
                            aluop_reg <= cmd_aluop;
                            case (cmd_type)
                                CMD_PUSH: begin
                                    if (count_reg == DEPTH_C) begin
                                        state_reg    <= S_ERR;
                                        err_code_reg <= ERR_OVF;
                                    end else begin
                                        state_reg    <= S_PUSH;
                                        q_opcode_reg <= OP_PUSH;
                                    end
                                end
                                CMD_REDUCE: begin
                                    if (count_reg < 3'd2) begin
                                        state_reg    <= S_ERR;
                                        err_code_reg <= ERR_UNF;
                                    end else begin
                                        state_reg <= S_CALC;
                                    end
                                end
                                CMD_RESULT: begin
                                    if (count_reg == 3'd0) begin
                                        state_reg    <= S_ERR;
                                        err_code_reg <= ERR_UNF;
                                    end else begin
                                        state_reg    <= S_POP;
                                        q_opcode_reg <= OP_POP;
                                    end
                                end
                                default: begin
                                    state_reg    <= S_CLEAR;
                                    q_opcode_reg <= (count_reg != 3'd0) ? OP_POP : OP_NOP;
                                end
                            endcase
                        end
                    end
                    S_PUSH: begin
                        count_reg    <= count_reg + 3'd1;
                        state_reg    <= S_IDLE;
                        q_opcode_reg <= OP_NOP;
                    end
                    S_CALC: begin
                        alu_reg      <= alu_next;
                        state_reg    <= S_WRITE;
                        q_opcode_reg <= OP_REPLACE;
                    end
                    S_WRITE: begin
                        count_reg    <= count_reg - 3'd1;
                        state_reg    <= S_IDLE;
                        q_opcode_reg <= OP_NOP;
                    end
                    S_POP: begin
                        res_data_reg  <= q_top_conc[W-1:0];
                        res_valid_reg <= 1'b1;
                        count_reg     <= count_reg - 3'd1;
                        state_reg     <= S_IDLE;
                        q_opcode_reg  <= OP_NOP;
                    end
                    S_CLEAR: begin
                        // the pop issued this cycle empties the queue when count is 1
                        if (count_reg > 3'd1) begin
                            count_reg    <= count_reg - 3'd1;
                            q_opcode_reg <= OP_POP;
                        end else begin
                            count_reg    <= 3'd0;
                            state_reg    <= S_IDLE;
                            q_opcode_reg <= OP_NOP;
                        end
                    end
                    S_ERR: begin
                        q_opcode_reg <= OP_NOP;
                        if (err_clr && !q_is_err) begin
                            state_reg    <= S_IDLE;
                            err_code_reg <= ERR_NONE;
                        end
                    end
                    default: begin
                        state_reg    <= S_IDLE;
                        q_opcode_reg <= OP_NOP;
                    end
                endcase
            end
        end
    end

    assign cmd_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign err       = (state_reg == S_ERR);
    assign q_opcode  = q_opcode_reg;
    assign q_back    = (state_reg == S_WRITE) ? alu_reg : data_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign count     = count_reg;
    assign err_code  = err_code_reg;

endmodule

// File: tb/tb_queue_calc_sequencer.sv
// Bench for queue_calc_sequencer: a behavioural operand queue answers the opcode bus and a
// command-level reference queue predicts counts, results, latencies and error codes.
module tb_queue_calc_sequencer;

    localparam int W     = 8;
    localparam int DEPTH = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_type;
    logic [W-1:0]   cmd_data;
    logic [1:0]     cmd_aluop;
    logic [1:0]     q_opcode;
    logic [W-1:0]   q_back;
    logic [2*W-1:0] q_top_conc;
    logic           q_is_err;
    logic           res_valid;
    logic [W-1:0]   res_data;
    logic [2:0]     count;
    logic           busy;
    logic           err;
    logic [1:0]     err_code;
    logic           err_clr;

    queue_calc_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_data   (cmd_data),
        .cmd_aluop  (cmd_aluop),
        .q_opcode   (q_opcode),
        .q_back     (q_back),
        .q_top_conc (q_top_conc),
        .q_is_err   (q_is_err),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .count      (count),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // behavioural operand queue sitting on the opcode bus
    logic [7:0] env_mem [0:7];
    int         env_cnt;
    logic       env_err;
    logic       force_err;
    int         n_push = 0;
    int         n_repl = 0;
    int         n_pop  = 0;
    logic [7:0] last_wb = 8'h00;

    assign q_top_conc = {(env_cnt >= 2) ? env_mem[1] : 8'hFF, (env_cnt >= 1) ? env_mem[0] : 8'hFF};
    assign q_is_err   = env_err | force_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            env_cnt <= 0;
            env_err <= 1'b0;
        end else begin
            case (q_opcode)
                2'b00: begin
                    n_push <= n_push + 1;
                    if (env_cnt >= DEPTH) env_err <= 1'b1;
                    else begin
                        env_mem[env_cnt] <= q_back;
                        env_cnt <= env_cnt + 1;
                    end
                end
                2'b10: begin
                    n_repl  <= n_repl + 1;
                    last_wb <= q_back;
                    if (env_cnt < 2) env_err <= 1'b1;
                    else begin
                        env_mem[0] <= q_back;
                        for (int i = 1; i < 7; i++) env_mem[i] <= env_mem[i+1];
                        env_cnt <= env_cnt - 1;
                    end
                end
                2'b11: begin
                    n_pop <= n_pop + 1;
                    if (env_cnt < 1) env_err <= 1'b1;
                    else begin
                        for (int i = 0; i < 7; i++) env_mem[i] <= env_mem[i+1];
                        env_cnt <= env_cnt - 1;
                    end
                end
                default: ;
            endcase
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input int a, input int b, input int op);
        case (op)
            0:       return 8'((a + b) % 256);
            1:       return 8'((a - b + 256) % 256);
            2:       return 8'(a & b);
            default: return 8'(a ^ b);
        endcase
    endfunction

    task automatic handshake(input logic [1:0] t, input logic [7:0] d, input logic [1:0] op);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_type  = t;
        cmd_data  = d;
        cmd_aluop = op;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] t, input logic [7:0] d, input logic [1:0] op,
                          output logic legal);
        int n, lat, exp_lat, exp_p, exp_r, exp_c, p0, r0, c0;
        logic [1:0] bad_code;
        logic [7:0] a, b, exp_res, exp_wb;
        n = ref_q.size();
        exp_p = 0; exp_r = 0; exp_c = 0; exp_res = 8'h00; exp_wb = 8'h00; bad_code = 2'b00;
        case (t)
            2'd0: begin legal = (n < DEPTH); exp_lat = 1; exp_p = 1; bad_code = 2'b01; end
            2'd1: begin legal = (n >= 2); exp_lat = 2; exp_r = 1; bad_code = 2'b10; end
            2'd2: begin legal = (n >= 1); exp_lat = 1; exp_c = 1; bad_code = 2'b10; end
            default: begin legal = 1'b1; exp_lat = (n == 0) ? 1 : n; exp_c = n; end
        endcase
        if (!legal) begin
            exp_lat = 0; exp_p = 0; exp_r = 0; exp_c = 0;
        end else begin
            case (t)
                2'd0: ref_q.push_back(d);
                2'd1: begin
                    a = ref_q.pop_front();
                    b = ref_q.pop_front();
                    exp_wb = alu_ref(int'(a), int'(b), int'(op));
                    ref_q.push_front(exp_wb);
                end
                2'd2: exp_res = ref_q.pop_front();
                default: ref_q.delete();
            endcase
        end
        p0 = n_push; r0 = n_repl; c0 = n_pop;
        handshake(t, d, op);
        lat = 0;
        while (!(cmd_ready === 1'b1 || err === 1'b1) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("push_ops", 32'(n_push - p0), 32'(exp_p));
        chk("replace_ops", 32'(n_repl - r0), 32'(exp_r));
        chk("pop_ops", 32'(n_pop - c0), 32'(exp_c));
        chk("count", 32'(count), 32'(ref_q.size()));
        chk("err", 32'(err), 32'(!legal));
        chk("err_code", 32'(err_code), legal ? 32'd0 : 32'(bad_code));
        chk("cmd_ready", 32'(cmd_ready), 32'(legal));
        if (legal && t == 2'd1) chk("write_back", 32'(last_wb), 32'(exp_wb));
        if (legal && t == 2'd2) begin
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("res_data", 32'(res_data), 32'(exp_res));
            @(negedge clk);
            chk("res_valid_pulse", 32'(res_valid), 32'd0);
        end else begin
            chk("res_valid_quiet", 32'(res_valid), 32'd0);
        end
        chk("queue_size", 32'(env_cnt), 32'(ref_q.size()));
        for (int i = 0; i < ref_q.size(); i++) chk("queue_entry", 32'(env_mem[i]), 32'(ref_q[i]));
        $display("txn type=%0d data=0x%02h aluop=%0d legal=%0b latency=%0d count=%0d err_code=%0d",
                 t, d, op, legal, lat, count, err_code);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_ready", 32'(cmd_ready), 32'd1);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_code", 32'(err_code), 32'd0);
        chk("clr_count", 32'(count), 32'(ref_q.size()));
        $display("txn err_clr count=%0d", count);
    endtask

    initial begin
        logic ok;
        int   r0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_data = '0; cmd_aluop = 2'b00;
        err_clr = 1'b0; force_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_q_opcode", 32'(q_opcode), 32'd1);
        chk("rst_q_back", 32'(q_back), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // add then sub through the front pair
        do_cmd(2'd0, 8'h03, 2'd0, ok);
        do_cmd(2'd0, 8'h05, 2'd0, ok);
        do_cmd(2'd1, 8'h00, 2'd0, ok);
        do_cmd(2'd2, 8'h00, 2'd0, ok);
        do_cmd(2'd0, 8'h03, 2'd0, ok);
        do_cmd(2'd0, 8'h05, 2'd0, ok);
        do_cmd(2'd1, 8'h00, 2'd1, ok);
        do_cmd(2'd2, 8'h00, 2'd0, ok);

        // overflow on the sixth push, recover, then drain five entries
        for (int i = 0; i < 6; i++) do_cmd(2'd0, 8'(8'h11 + i), 2'd0, ok);
        clear_err();
        do_cmd(2'd3, 8'h00, 2'd0, ok);

        // underflow cases
        do_cmd(2'd0, 8'h07, 2'd0, ok);
        do_cmd(2'd1, 8'h00, 2'd0, ok);
        clear_err();
        do_cmd(2'd3, 8'h00, 2'd0, ok);
        do_cmd(2'd2, 8'h00, 2'd0, ok);
        clear_err();

        // four pops on clear, then a clear of an empty queue
        for (int i = 0; i < 4; i++) do_cmd(2'd0, 8'($urandom), 2'd0, ok);
        do_cmd(2'd3, 8'h00, 2'd0, ok);
        do_cmd(2'd3, 8'h00, 2'd0, ok);

        // randomized command mix
        for (int i = 0; i < 80; i++) begin
            int sel;
            logic [1:0] t;
            sel = int'($urandom_range(0, 9));
            t = (sel < 5) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            do_cmd(t, 8'($urandom), 2'($urandom_range(0, 3)), ok);
            if (!ok) clear_err();
        end

        // reset while a REDUCE is in CALC
        do_cmd(2'd3, 8'h00, 2'd0, ok);
        do_cmd(2'd0, 8'h21, 2'd0, ok);
        do_cmd(2'd0, 8'h42, 2'd0, ok);
        r0 = n_repl;
        handshake(2'd1, 8'h00, 2'd0);
        rst = 1'b1;
        #1;
        chk("abort_q_opcode", 32'(q_opcode), 32'd1);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        ref_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_write", 32'(n_repl - r0), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        $display("txn reset_during_calc count=%0d", count);

        // queue error in IDLE is sticky until reset
        do_cmd(2'd0, 8'h5A, 2'd0, ok);
        force_err = 1'b1;
        @(negedge clk);
        chk("qerr_err", 32'(err), 32'd1);
        chk("qerr_code", 32'(err_code), 32'd3);
        chk("qerr_ready", 32'(cmd_ready), 32'd0);
        err_clr = 1'b1;
        repeat (2) @(negedge clk);
        err_clr = 1'b0;
        chk("qerr_clr_ignored", 32'(err), 32'd1);
        chk("qerr_code_held", 32'(err_code), 32'd3);
        chk("qerr_count_held", 32'(count), 32'd1);
        rst = 1'b1;
        force_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_q.delete();
        @(negedge clk);
        chk("qerr_rst_err", 32'(err), 32'd0);
        chk("qerr_rst_code", 32'(err_code), 32'd0);
        chk("qerr_rst_ready", 32'(cmd_ready), 32'd1);
        $display("txn queue_error_then_reset err=%0b", err);

        do_cmd(2'd0, 8'h99, 2'd0, ok);
        do_cmd(2'd2, 8'h00, 2'd0, ok);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
